// File: rtl/nabp_filtered_ram_swap_control_if.sv
// Filtered-projection store bus: filter write stream, next-angle handshake,
// and two signed-s read ports.
interface nabp_filtered_ram_swap_control_if #(
  parameter int ANGLE_LEN = 9,
  parameter int DATA_LEN  = 16,
  parameter int S_LEN     = 9
);
  logic                        filt_valid;
  logic signed [DATA_LEN-1:0]  filt_data;
  logic                        filt_ready;
  logic                        fr_next_angle;
  logic                        fr_next_angle_ack;
  logic        [ANGLE_LEN-1:0] fr_angle;
  logic                        fr_has_next_angle;
  logic signed [S_LEN-1:0]     fr0_s_val;
  logic signed [S_LEN-1:0]     fr1_s_val;
  logic signed [DATA_LEN-1:0]  fr0_val;
  logic signed [DATA_LEN-1:0]  fr1_val;

  modport master (
    output filt_valid, filt_data, fr_next_angle, fr0_s_val, fr1_s_val,
    input  filt_ready, fr_next_angle_ack, fr_angle, fr_has_next_angle, fr0_val, fr1_val
  );

  modport slave (
    input  filt_valid, filt_data, fr_next_angle, fr0_s_val, fr1_s_val,
    output filt_ready, fr_next_angle_ack, fr_angle, fr_has_next_angle, fr0_val, fr1_val
  );
endinterface

// File: rtl/nabp_filtered_ram_swap_control.sv
// Ping-pong store of filtered projection lines: filter writes fill banks,
// processing side claims them one angle at a time and reads by signed s.
module nabp_filtered_ram_swap_control #(
  parameter int ANGLE_LEN     = 9,
  parameter int DATA_LEN      = 16,
  parameter int S_LEN         = 9,
  parameter int PROJ_LINES    = 256,
  parameter int NO_OF_ANGLES  = 180,
  parameter int ANGLE_STEP    = 1,
  parameter int RELEASE_DELAY = 4
) (
  input logic clk,
  input logic reset,
  nabp_filtered_ram_swap_control_if.slave bus
);

  localparam int AW = (PROJ_LINES > 1) ? $clog2(PROJ_LINES) : 1;
  localparam int CW = $clog2(NO_OF_ANGLES + 1);
  localparam int DW = (RELEASE_DELAY > 0) ? $clog2(RELEASE_DELAY + 1) : 1;

  localparam logic [CW-1:0]  ANGLES    = CW'(NO_OF_ANGLES);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(PROJ_LINES - 1);
  localparam logic [S_LEN:0] HALF      = (S_LEN + 1)'(PROJ_LINES / 2);
  localparam logic [S_LEN:0] LINES     = (S_LEN + 1)'(PROJ_LINES);
  localparam logic [DW-1:0]  DRAIN_LD  = DW'(RELEASE_DELAY);

  typedef enum logic [1:0] {EMPTY, FULL, IN_USE, DRAIN} bank_state_t;

  logic signed [DATA_LEN-1:0] mem [2][PROJ_LINES];

  bank_state_t          bank_state   [2];
  bank_state_t          bank_state_n [2];
  logic [DW-1:0]        drain_cnt    [2];
  logic [DW-1:0]        drain_cnt_n  [2];
  logic [ANGLE_LEN-1:0] tag          [2];

  logic                 wr_bank;
  logic [AW-1:0]        wr_addr;
  logic [CW-1:0]        wr_cnt;
  logic                 rd_next;
  logic                 rd_cur;
  logic                 rd_valid;
  logic [CW-1:0]        served;
  logic                 ack;
  logic                 ack_q;
  logic [ANGLE_LEN-1:0] angle_q;

  logic                 wr_ready;
  logic                 wr_fire;
  logic                 wr_last;

  logic [S_LEN:0]       idx0;
  logic [S_LEN:0]       idx1;
  logic                 hit0;
  logic                 hit1;
  logic signed [DATA_LEN-1:0] val0_q;
  logic signed [DATA_LEN-1:0] val1_q;

  assign wr_ready = !reset && (bank_state[wr_bank] == EMPTY) && (wr_cnt < ANGLES);
  assign wr_fire  = bus.filt_valid && wr_ready;
  assign wr_last  = wr_fire && (wr_addr == LAST_ADDR);

  // ack_q blocks a second grant on the cycle right after one, even with the request held
  assign ack = !reset && bus.fr_next_angle && (bank_state[rd_next] == FULL) && !ack_q;

  assign bus.filt_ready        = wr_ready;
  assign bus.fr_next_angle_ack = ack;
  assign bus.fr_angle          = angle_q;
  assign bus.fr_has_next_angle = (served < ANGLES);
  assign bus.fr0_val           = val0_q;
  assign bus.fr1_val           = val1_q;

  // Offset s into a 0-based line index; negative or past-the-end reads return 0
  always_comb begin
    idx0 = {bus.fr0_s_val[S_LEN-1], bus.fr0_s_val} + HALF;
    idx1 = {bus.fr1_s_val[S_LEN-1], bus.fr1_s_val} + HALF;
    hit0 = rd_valid && !idx0[S_LEN] && (idx0 < LINES);
    hit1 = rd_valid && !idx1[S_LEN] && (idx1 < LINES);
  end

  always_comb begin
    bank_state_n = bank_state;
    drain_cnt_n  = drain_cnt;
    for (int unsigned b = 0; b < 2; b++) begin
      if (bank_state[b] == DRAIN) begin
        if (drain_cnt[b] <= DW'(1)) begin
          bank_state_n[b] = EMPTY;
          drain_cnt_n[b]  = '0;
        end else begin
          drain_cnt_n[b]  = drain_cnt[b] - DW'(1);
        end
      end
    end
    if (wr_last) begin
      bank_state_n[wr_bank] = FULL;
    end
    if (ack) begin
      bank_state_n[rd_next] = IN_USE;
      if (rd_valid) begin
        bank_state_n[rd_cur] = DRAIN;
        drain_cnt_n[rd_cur]  = DRAIN_LD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_state <= '{EMPTY, EMPTY};
      drain_cnt  <= '{'0, '0};
      tag        <= '{'0, '0};
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      wr_cnt     <= '0;
      rd_next    <= 1'b0;
      rd_cur     <= 1'b0;
      rd_valid   <= 1'b0;
      served     <= '0;
      ack_q      <= 1'b0;
      angle_q    <= '0;
    end else begin
      bank_state <= bank_state_n;
      drain_cnt  <= drain_cnt_n;
      ack_q      <= ack;
      if (wr_fire) begin
        wr_addr <= wr_addr + AW'(1);
        if (wr_last) begin
          tag[wr_bank] <= ANGLE_LEN'(32'(wr_cnt) * ANGLE_STEP);
          wr_bank      <= ~wr_bank;
          wr_cnt       <= wr_cnt + CW'(1);
        end
      end
      if (ack) begin
        rd_cur   <= rd_next;
        rd_next  <= ~rd_next;
        rd_valid <= 1'b1;
        served   <= served + CW'(1);
        angle_q  <= tag[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_addr] <= bus.filt_data;
    end
  end

  // rd_cur is the pre-edge value, so a read in the ack cycle still sees the old bank
  always_ff @(posedge clk) begin
    if (reset) begin
      val0_q <= '0;
      val1_q <= '0;
    end else begin
      val0_q <= hit0 ? mem[rd_cur][idx0[AW-1:0]] : '0;
      val1_q <= hit1 ? mem[rd_cur][idx1[AW-1:0]] : '0;
    end
  end

endmodule
